// File: rtl/z80_wb_timer_resp.sv
// z80_wb_timer_resp
//
// Wishbone responder for the Z80 core's external bus. It implements a
// programmable interval timer with its interrupt. The timer occupies an
// 8-port I/O window at BASE. The responder also answers the
// interrupt-acknowledge cycle by returning the vector byte.
//
// Ports
//   wb_clk_i   in   1   clock
//   wb_rst_i   in   1   synchronous active-high reset
//   wb_adr_i   in  16   address; only [7:0] decoded ([2:0] = register offset)
//   wb_dat_i   in   8   write data
//   wb_we_i    in   1   write enable
//   wb_cyc_i   in   1   cycle valid
//   wb_stb_i   in   1   strobe
//   wb_tga_i   in   2   cycle tag (memory / I/O / int-ack)
//   wb_dat_o   out  8   read data, 8'h00 whenever wb_ack_o is low
//   wb_ack_o   out  1   single-cycle registered acknowledge
//   int_req_o  out  1   level interrupt request (pending & IE)
//
// Register map (offset = wb_adr_i[2:0])
//   0 CTRL   R/W  bit0 EN, bit1 AUTO, bit2 IE
//   1 RLD_LO R/W  2 RLD_HI R/W
//   3 VECTOR R/W  byte returned on int-ack
//   4 STATUS      read bit0 = pending, write bit0=1 clears pending
//   5 CNT_LO RO   reading also snapshots count[15:8]
//   6 CNT_HI RO   snapshot from the last CNT_LO read
//   7 reserved    reads 0, writes ignored

module z80_wb_timer_resp #(
    parameter logic [7:0] BASE        = 8'h40,
    parameter int         WAIT_STATES = 0,
    parameter int         PRESCALE    = 16,
    parameter logic [1:0] TAG_IO      = 2'b01,
    parameter logic [1:0] TAG_INTA    = 2'b10
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] wb_adr_i,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [1:0]  wb_tga_i,
    output logic [7:0]  wb_dat_o,
    output logic        wb_ack_o,
    output logic        int_req_o
);

    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [3:0]      WAIT_INIT  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt, wait_cnt_next;

    logic        sel;
    logic        commit;
    logic        is_inta;
    logic        is_io_wr;
    logic        is_io_rd;
    logic [2:0]  off;
    logic [7:0]  rd_mux;
    logic [7:0]  ack_data;

    logic [2:0]  ctrl;
    logic [15:0] reload;
    logic [7:0]  vector;
    logic        pending;
    logic [15:0] count;
    logic [PW-1:0] presc;
    logic [7:0]  cnt_hi_snap;

    logic        tick;
    logic        expire;
    logic        pend_clr;

    // Upper address byte is not part of the I/O decode.
    logic        unused_adr;
    assign unused_adr = ^wb_adr_i[15:8];

    assign off = wb_adr_i[2:0];
    assign sel = wb_cyc_i & wb_stb_i &
                 (((wb_tga_i == TAG_IO) & (wb_adr_i[7:3] == BASE[7:3])) |
                  (wb_tga_i == TAG_INTA));

    // Handshake next-state. The commit strobe marks the edge that raises
    // wb_ack_o; all register side effects are qualified by it, so an aborted
    // or ignored cycle never touches state. In WAIT the full select is
    // re-checked, so a dropped strobe or cycle returns to IDLE silently.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        commit        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel) begin
                    if (WAIT_INIT == 4'd0) begin
                        state_next = ST_ACK;
                        commit     = 1'b1;
                    end else begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!sel) begin
                    state_next    = ST_IDLE;
                    wait_cnt_next = 4'd0;
                end else if (wait_cnt == 4'd1) begin
                    state_next    = ST_ACK;
                    wait_cnt_next = 4'd0;
                    commit        = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    assign is_inta  = commit & (wb_tga_i == TAG_INTA);
    assign is_io_wr = commit & (wb_tga_i == TAG_IO) & wb_we_i;
    assign is_io_rd = commit & (wb_tga_i == TAG_IO) & ~wb_we_i;

    // Read mux sees pre-edge register values.
    always_comb begin
        rd_mux = 8'h00;
        case (off)
            3'd0:    rd_mux = {5'b00000, ctrl};
            3'd1:    rd_mux = reload[7:0];
            3'd2:    rd_mux = reload[15:8];
            3'd3:    rd_mux = vector;
            3'd4:    rd_mux = {7'b0000000, pending};
            3'd5:    rd_mux = count[7:0];
            3'd6:    rd_mux = cnt_hi_snap;
            default: rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        ack_data = 8'h00;
        if (is_inta) begin
            ack_data = vector;
        end else if (is_io_rd) begin
            ack_data = rd_mux;
        end
    end

    // Timer set of pending wins over any clear on the same edge.
    assign tick     = ctrl[0] & (presc == PRESC_LAST);
    assign expire   = tick & (count == 16'h0000);
    assign pend_clr = (is_io_wr & (off == 3'd4) & wb_dat_i[0]) | is_inta;

    assign int_req_o = pending & ctrl[2];

    // ---- handshake stage: state, wait counter, registered ack/data ----
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= 8'h00;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            wb_ack_o <= commit;
            wb_dat_o <= ack_data;
        end
    end

    // ---- register / timer stage ----
    // Bus writes are placed after the timer update so a CTRL write overrides
    // the timer's own EN clear on a coinciding expiry.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl        <= 3'b000;
            reload      <= 16'h0000;
            vector      <= 8'hFF;
            pending     <= 1'b0;
            count       <= 16'h0000;
            presc       <= '0;
            cnt_hi_snap <= 8'h00;
        end else begin
            if (tick) begin
                presc <= '0;
                if (count == 16'h0000) begin
                    if (ctrl[1]) begin
                        count <= reload;
                    end else begin
                        ctrl[0] <= 1'b0;
                    end
                end else begin
                    count <= count - 16'd1;
                end
            end else if (ctrl[0]) begin
                presc <= presc + PW'(1);
            end

            if (expire) begin
                pending <= 1'b1;
            end else if (pend_clr) begin
                pending <= 1'b0;
            end

            if (is_io_wr) begin
                case (off)
                    3'd0: begin
                        ctrl <= wb_dat_i[2:0];
                        // EN rising restarts the period from the reload value.
                        if (wb_dat_i[0] && !ctrl[0]) begin
                            count <= reload;
                            presc <= '0;
                        end
                    end
                    3'd1:    reload[7:0]  <= wb_dat_i;
                    3'd2:    reload[15:8] <= wb_dat_i;
                    3'd3:    vector       <= wb_dat_i;
                    default: ;
                endcase
            end

            if (is_io_rd && (off == 3'd5)) begin
                cnt_hi_snap <= count[15:8];
            end
        end
    end

endmodule

// File: tb/tb_z80_wb_timer_resp.sv
module tb_z80_wb_timer_resp;

    localparam logic [7:0] BASE     = 8'h40;
    localparam int         W        = 2;
    localparam int         P        = 4;
    localparam logic [1:0] TAG_MEM  = 2'b00;
    localparam logic [1:0] TAG_IO   = 2'b01;
    localparam logic [1:0] TAG_INTA = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] adr;
    logic [7:0]  dat_w;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [1:0]  tga;
    logic [7:0]  dat_r;
    logic        ack;
    logic        irq;

    always #5 clk = ~clk;

    z80_wb_timer_resp #(
        .BASE        (BASE),
        .WAIT_STATES (W),
        .PRESCALE    (P),
        .TAG_IO      (TAG_IO),
        .TAG_INTA    (TAG_INTA)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat_w),
        .wb_we_i   (we),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_tga_i  (tga),
        .wb_dat_o  (dat_r),
        .wb_ack_o  (ack),
        .int_req_o (irq)
    );

    int ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    typedef struct {
        int         edge_n;
        logic [7:0] data;
        logic       irq;
    } exp_item_t;

    exp_item_t exp_q[$];
    exp_item_t mon_it;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d)", name, got, exp, ecount);
        end
    endtask

    // ---------------- reference model ----------------
    // The timer is described by segments: a segment starts at an edge with a
    // start value; ticks fall every P edges after it, and the period expires
    // on the tick after reaching zero.
    bit          m_en, m_auto, m_ie, m_pend;
    logic [15:0] m_rld;
    logic [7:0]  m_vec, m_snap;
    int          m_seg_start, m_seg_val, m_frozen;

    task automatic m_reset();
        m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0;
        m_rld = 16'h0000; m_vec = 8'hFF; m_snap = 8'h00;
        m_seg_start = 0; m_seg_val = 0; m_frozen = 0;
    endtask

    function automatic int exp_edge();
        return m_seg_start + P * (m_seg_val + 1);
    endfunction

    function automatic int cnt_after(input int t);
        return m_seg_val - (t - m_seg_start) / P;
    endfunction

    task automatic apply_expiry(input int e);
        m_pend = 1;
        if (m_auto) begin
            m_seg_start = e;
            m_seg_val   = int'(m_rld);
        end else begin
            m_en     = 0;
            m_frozen = 0;
        end
    endtask

    task automatic advance(input int t);
        while (m_en && exp_edge() <= t) apply_expiry(exp_edge());
    endtask

    task automatic model_commit(input int c, input logic [1:0] tg, input logic [2:0] off,
                                input logic w, input logic [7:0] d);
        logic [15:0] cnt;
        logic [7:0]  rd;
        bit          old_en, old_auto, exp_t;
        exp_item_t   it;
        advance(c - 1);
        cnt = m_en ? 16'(cnt_after(c - 1)) : 16'(m_frozen);
        rd  = 8'h00;
        if (tg == TAG_INTA) begin
            rd = m_vec;
        end else if (!w) begin
            case (off)
                3'd0: rd = {5'b0, m_ie, m_auto, m_en};
                3'd1: rd = m_rld[7:0];
                3'd2: rd = m_rld[15:8];
                3'd3: rd = m_vec;
                3'd4: rd = {7'b0, m_pend};
                3'd5: begin rd = cnt[7:0]; m_snap = cnt[15:8]; end
                3'd6: rd = m_snap;
                default: rd = 8'h00;
            endcase
        end
        old_en   = m_en;
        old_auto = m_auto;
        exp_t    = m_en && (exp_edge() == c);
        if (exp_t) apply_expiry(c);
        if (tg == TAG_IO && w) begin
            case (off)
                3'd0: begin
                    if (d[0]) begin
                        if (!old_en) begin
                            m_seg_start = c; m_seg_val = int'(m_rld);
                        end else if (exp_t && !old_auto) begin
                            m_seg_start = c; m_seg_val = 0;
                        end
                    end else if (m_en) begin
                        m_frozen = cnt_after(c);
                    end
                    m_en = d[0]; m_auto = d[1]; m_ie = d[2];
                end
                3'd1: m_rld[7:0]  = d;
                3'd2: m_rld[15:8] = d;
                3'd3: m_vec = d;
                3'd4: if (d[0] && !exp_t) m_pend = 0;
                default: ;
            endcase
        end
        if (tg == TAG_INTA && !exp_t) m_pend = 0;
        it.edge_n = c;
        it.data   = rd;
        it.irq    = m_pend & m_ie;
        exp_q.push_back(it);
    endtask

    // ---------------- bus driver ----------------
    task automatic do_txn(input logic [1:0] tg, input logic [15:0] a, input logic w,
                          input logic [7:0] d, input bit abort_it, output int c_out);
        int k;
        bit s;
        @(negedge clk);
        k = ecount + 1;
        s = ((tg == TAG_IO) && (a[7:3] == BASE[7:3])) || (tg == TAG_INTA);
        tga = tg; adr = a; we = w; dat_w = d; cyc = 1'b1; stb = 1'b1;
        c_out = -1;
        if (!s) begin
            repeat (W + 2) @(negedge clk);
        end else if (abort_it) begin
            @(negedge clk);
            stb = 1'b0;
            repeat (W + 1) @(negedge clk);
        end else begin
            c_out = k + W;
            model_commit(c_out, tg, a[2:0], w, d);
            repeat (W + 1) @(negedge clk);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_on) begin
            if (ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    mon_it = exp_q.pop_front();
                    chk("ack_edge", 32'(ecount), 32'(mon_it.edge_n));
                    chk("ack_data", 32'(dat_r), 32'(mon_it.data));
                    chk("ack_irq", 32'(irq), 32'(mon_it.irq));
                end
            end else begin
                chk("idle_dat_zero", 32'(dat_r), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: timeout at edge %0d", ecount);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c, e, r;
        logic [1:0]  tg;
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
        bit          ab;

        rst = 1'b1; adr = 16'h0000; dat_w = 8'h00; we = 1'b0;
        cyc = 1'b0; stb = 1'b0; tga = TAG_MEM;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_reset();
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_dat", 32'(dat_r), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        mon_on = 1'b1;

        // Vector reset value
        do_txn(TAG_IO, 16'h0043, 1'b0, 8'h00, 0, c);

        // Auto-reload period: reload 2, prescale 4 -> 12 cycles
        do_txn(TAG_IO, 16'h0041, 1'b1, 8'h02, 0, c);
        do_txn(TAG_IO, 16'h0042, 1'b1, 8'h00, 0, c);
        do_txn(TAG_IO, 16'h0043, 1'b1, 8'hD7, 0, c);
        do_txn(TAG_IO, 16'h0040, 1'b1, 8'h07, 0, c);
        e = c;
        while (ecount < e + 11) @(negedge clk);
        chk("irq_before_expiry", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_at_expiry", 32'(irq), 32'd1);
        do_txn(TAG_INTA, 16'h1234, 1'b0, 8'h00, 0, c);
        do_txn(TAG_IO, 16'h0044, 1'b0, 8'h00, 0, c);

        // Count snapshot while counting down from 16'h0100
        do_txn(TAG_IO, 16'h0040, 1'b1, 8'h00, 0, c);
        do_txn(TAG_IO, 16'h0041, 1'b1, 8'h00, 0, c);
        do_txn(TAG_IO, 16'h0042, 1'b1, 8'h01, 0, c);
        do_txn(TAG_IO, 16'h0040, 1'b1, 8'h01, 0, c);
        do_txn(TAG_IO, 16'h0045, 1'b0, 8'h00, 0, c);
        do_txn(TAG_IO, 16'h0046, 1'b0, 8'h00, 0, c);

        // Ignored cycles and abort
        do_txn(TAG_MEM, 16'h0040, 1'b1, 8'h00, 0, c);
        do_txn(TAG_IO, 16'h0048, 1'b1, 8'h00, 0, c);
        do_txn(TAG_IO, 16'h0040, 1'b0, 8'h00, 0, c);
        do_txn(TAG_IO, 16'h0043, 1'b1, 8'h11, 1, c);
        do_txn(TAG_IO, 16'h0043, 1'b0, 8'h00, 0, c);

        // Timer set and STATUS clear on the same edge, one-shot
        do_txn(TAG_IO, 16'h0040, 1'b1, 8'h00, 0, c);
        do_txn(TAG_IO, 16'h0044, 1'b1, 8'h01, 0, c);
        do_txn(TAG_IO, 16'h0042, 1'b1, 8'h00, 0, c);
        do_txn(TAG_IO, 16'h0041, 1'b1, 8'h01, 0, c);
        do_txn(TAG_IO, 16'h0040, 1'b1, 8'h01, 0, c);
        e = c;
        while (ecount < e + 4) @(negedge clk);
        do_txn(TAG_IO, 16'h0044, 1'b1, 8'h01, 0, c);
        chk("same_edge_commit", 32'(c), 32'(e + 2 * P));
        do_txn(TAG_IO, 16'h0044, 1'b0, 8'h00, 0, c);
        do_txn(TAG_IO, 16'h0040, 1'b0, 8'h00, 0, c);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 9);
            tg = (r < 1) ? TAG_MEM : (r < 2) ? 2'b11 : (r < 3) ? TAG_INTA : TAG_IO;
            a[15:8] = 8'($urandom);
            if ($urandom_range(0, 5) == 0) a[7:0] = 8'($urandom);
            else a[7:0] = {BASE[7:3], 3'($urandom)};
            w = 1'($urandom);
            d = 8'($urandom);
            if (tg == TAG_IO && w) begin
                if (a[2:0] == 3'd2 && $urandom_range(0, 3) != 0) d = 8'h00;
                if (a[2:0] == 3'd1) d = d & 8'h1F;
                if (a[2:0] == 3'd0) d[0] = ($urandom_range(0, 3) != 0);
            end
            ab = ($urandom_range(0, 9) == 0);
            do_txn(tg, a, w, d, ab, c);
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end

        // Reset in the middle of a write
        @(negedge clk);
        tga = TAG_IO; adr = 16'h0043; we = 1'b1; dat_w = 8'h5A; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        m_reset();
        exp_q.delete();
        chk("midreset_irq", 32'(irq), 32'd0);
        do_txn(TAG_IO, 16'h0043, 1'b0, 8'h00, 0, c);
        do_txn(TAG_IO, 16'h0040, 1'b0, 8'h00, 0, c);
        do_txn(TAG_IO, 16'h0041, 1'b0, 8'h00, 0, c);

        repeat (W + 4) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
